// File: rtl/mandelbrot_rx.sv
// Capture-side receiver for the Mandelbrot core count stream: edge-detects new_ctr,
// tags each count with its raster coordinate, and queues {x, y, ctr} in a small FIFO.
// Optional input synchronizers: define MANDELBROT_RX_SYNC_EN.
module mandelbrot_rx #(
    parameter int CTRWIDTH = 7,
    parameter int WIDTH    = 64,
    parameter int HEIGHT   = 48,
    parameter int XW       = 6,
    parameter int YW       = 6,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CTRWIDTH-1:0] ctr_in,
    input  logic                new_ctr,
    input  logic                clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XW-1:0]       out_x,
    output logic [YW-1:0]       out_y,
    output logic [CTRWIDTH-1:0] out_ctr,
    output logic                out_in_set,
    output logic                frame_done,
    output logic                overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                strobe;
    logic [CTRWIDTH-1:0] ctr_cap;

`ifdef MANDELBROT_RX_SYNC_EN
    logic [1:0]          strb_sync;
    logic [CTRWIDTH-1:0] ctr_s1, ctr_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strb_sync <= '0;
            ctr_s1    <= '0;
            ctr_s2    <= '0;
        end else begin
            strb_sync <= {strb_sync[0], new_ctr};
            ctr_s1    <= ctr_in;
            ctr_s2    <= ctr_s1;
        end
    end

    assign strobe  = strb_sync[1];
    assign ctr_cap = ctr_s2;
`else
    assign strobe  = new_ctr;
    assign ctr_cap = ctr_in;
`endif

    logic                prev;
    logic                cap, take, push, pop, drop, full;
    logic                x_last, y_last;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [AW:0]         count;
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [XW-1:0]       mem_x [DEPTH];
    logic [YW-1:0]       mem_y [DEPTH];
    logic [CTRWIDTH-1:0] mem_c [DEPTH];

    assign cap    = strobe & ~prev;
    assign full   = (count == (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign pop    = out_valid & out_ready;
    assign take   = cap & ~clear;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push   = take & (~full | pop);
    assign drop   = take & full & ~pop;
    assign x_last = (x == XW'(WIDTH - 1));
    assign y_last = (y == YW'(HEIGHT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= 1'b0;
            x          <= '0;
            y          <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_x[i] <= '0;
                mem_y[i] <= '0;
                mem_c[i] <= '0;
            end
        end else begin
            prev <= strobe;
            if (clear) begin
                x          <= '0;
                y          <= '0;
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                overflow   <= 1'b0;
                frame_done <= 1'b0;
            end else begin
                if (push) begin
                    mem_x[wr_ptr] <= x;
                    mem_y[wr_ptr] <= y;
                    mem_c[wr_ptr] <= ctr_cap;
                    wr_ptr        <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (drop)
                    overflow <= 1'b1;
                frame_done <= take & x_last & y_last;
                // Coordinates advance even on a dropped sample to keep alignment.
                if (take) begin
                    if (x_last) begin
                        x <= '0;
                        y <= y_last ? '0 : y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
            end
        end
    end

    assign out_x      = out_valid ? mem_x[rd_ptr] : '0;
    assign out_y      = out_valid ? mem_y[rd_ptr] : '0;
    assign out_ctr    = out_valid ? mem_c[rd_ptr] : '0;
    assign out_in_set = out_valid & (&mem_c[rd_ptr]);

endmodule
